// File: rtl/instruction_encoder_pkg.sv
// Shared encodings and limits for the RV32I instruction encoder.
package instruction_encoder_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned SRC_W     = 3;
  localparam int unsigned OPC_W     = 7;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned FUNCT7_W  = 7;
  localparam int unsigned ERR_CNT_W = 8;

  typedef enum logic [SRC_W-1:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_R = 3'd5
  } imm_src_e;

  localparam logic [OPC_W-1:0] OP_R    = 7'h33;
  localparam logic [OPC_W-1:0] OP_I    = 7'h13;
  localparam logic [OPC_W-1:0] OP_LOAD = 7'h03;
  localparam logic [OPC_W-1:0] OP_S    = 7'h23;
  localparam logic [OPC_W-1:0] OP_B    = 7'h63;
  localparam logic [OPC_W-1:0] OP_LUI  = 7'h37;
  localparam logic [OPC_W-1:0] OP_JAL  = 7'h6F;

  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed IMM13_MIN = -4096;
  localparam int signed IMM13_MAX = 4094;
  localparam int signed IMM21_MIN = -1048576;
  localparam int signed IMM21_MAX = 1048574;

  typedef struct packed {
    logic [SRC_W-1:0]    imm_src;
    logic [OPC_W-1:0]    opcode;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [FUNCT3_W-1:0] funct3;
    logic [FUNCT7_W-1:0] funct7;
    logic [XLEN-1:0]     imm;
  } enc_req_t;

  function automatic logic imm_in_range(input logic signed [XLEN-1:0] imm,
                                        input int signed lo, input int signed hi);
    return (imm >= lo) && (imm <= hi);
  endfunction

endpackage

// File: rtl/instruction_encoder_sync_fifo.sv
// Synchronous FIFO with occupancy count; push while full is allowed when a pop frees the slot.
module sync_fifo
  import instruction_encoder_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// Packs RV32I fields and an immediate into an instruction word, range-checks it, and buffers legal words.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [SRC_W-1:0]      i_ImmSrc,
  input  logic [OPC_W-1:0]      i_opcode,
  input  logic [REG_W-1:0]      i_rd,
  input  logic [REG_W-1:0]      i_rs1,
  input  logic [REG_W-1:0]      i_rs2,
  input  logic [FUNCT3_W-1:0]   i_funct3,
  input  logic [FUNCT7_W-1:0]   i_funct7,
  input  logic [XLEN-1:0]       i_immediate,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [XLEN-1:0]       o_instruction,
  output logic                  o_err,
  output logic [ERR_CNT_W-1:0]  o_err_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  enc_req_t            w_req;
  logic [XLEN-1:0]     w_word;
  logic                w_legal;
  logic                w_accept;
  logic [CNT_W-1:0]    w_count;
  logic [CNT_W:0]      w_occupancy;
  logic                w_empty;

  logic                r_stage_valid;
  logic                r_stage_err;
  logic [XLEN-1:0]     r_stage_word;
  logic [ERR_CNT_W-1:0] r_err_count;

  assign w_req = '{imm_src: i_ImmSrc, opcode: i_opcode, rd: i_rd, rs1: i_rs1,
                   rs2: i_rs2, funct3: i_funct3, funct7: i_funct7, imm: i_immediate};

  // Format-specific bit packing and immediate legality
  always_comb begin
    w_word  = '0;
    w_legal = 1'b0;
    case (w_req.imm_src)
      IMM_I: begin
        w_word  = {w_req.imm[11:0], w_req.rs1, w_req.funct3, w_req.rd, w_req.opcode};
        w_legal = imm_in_range(w_req.imm, IMM12_MIN, IMM12_MAX);
      end
      IMM_S: begin
        w_word  = {w_req.imm[11:5], w_req.rs2, w_req.rs1, w_req.funct3,
                   w_req.imm[4:0], w_req.opcode};
        w_legal = imm_in_range(w_req.imm, IMM12_MIN, IMM12_MAX);
      end
      IMM_B: begin
        w_word  = {w_req.imm[12], w_req.imm[10:5], w_req.rs2, w_req.rs1, w_req.funct3,
                   w_req.imm[4:1], w_req.imm[11], w_req.opcode};
        w_legal = imm_in_range(w_req.imm, IMM13_MIN, IMM13_MAX) && !w_req.imm[0];
      end
      IMM_U: begin
        w_word  = {w_req.imm[31:12], w_req.rd, w_req.opcode};
        w_legal = (w_req.imm[11:0] == 12'd0);
      end
      IMM_J: begin
        w_word  = {w_req.imm[20], w_req.imm[10:1], w_req.imm[11], w_req.imm[19:12],
                   w_req.rd, w_req.opcode};
        w_legal = imm_in_range(w_req.imm, IMM21_MIN, IMM21_MAX) && !w_req.imm[0];
      end
      IMM_R: begin
        w_word  = {w_req.funct7, w_req.rs2, w_req.rs1, w_req.funct3, w_req.rd, w_req.opcode};
        w_legal = 1'b1;
      end
      default: begin
        w_word  = '0;
        w_legal = 1'b0;
      end
    endcase
  end

  // Space is reserved for the staged word so the stage can always drain
  assign w_occupancy = {1'b0, w_count} + (CNT_W+1)'(r_stage_valid);
  assign o_ready     = (w_occupancy < (CNT_W+1)'(DEPTH));
  assign w_accept    = i_valid && o_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stage_valid <= 1'b0;
      r_stage_err   <= 1'b0;
      r_stage_word  <= '0;
      r_err_count   <= '0;
    end else begin
      r_stage_valid <= w_accept;
      r_stage_err   <= w_accept && !w_legal;
      if (w_accept) r_stage_word <= w_word;
      if (r_stage_err && (r_err_count != {ERR_CNT_W{1'b1}}))
        r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_stage_valid && !r_stage_err),
    .i_data  (r_stage_word),
    .i_pop   (i_ready),
    .o_data  (o_instruction),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign o_valid     = !w_empty;
  assign o_err       = r_stage_err;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: encodings, range errors, backpressure, full-FIFO streaming, reset.
module tb_instruction_encoder;
  import instruction_encoder_pkg::*;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_ImmSrc;
  logic [6:0]  i_opcode;
  logic [4:0]  i_rd, i_rs1, i_rs2;
  logic [2:0]  i_funct3;
  logic [6:0]  i_funct7;
  logic [31:0] i_immediate;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instruction;
  logic        o_err;
  logic [7:0]  o_err_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_err  = 0;
  logic [31:0] exp_q[$];

  instruction_encoder #(.DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_ImmSrc(i_ImmSrc), .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1),
    .i_rs2(i_rs2), .i_funct3(i_funct3), .i_funct7(i_funct7),
    .i_immediate(i_immediate), .o_valid(o_valid), .i_ready(i_ready),
    .o_instruction(o_instruction), .o_err(o_err), .o_err_count(o_err_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Every word leaving the FIFO must match the head of the expected queue
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) check("pop_with_empty_queue", 32'(exp_q.size()), 32'd1);
      else check("fifo_word", o_instruction, exp_q.pop_front());
    end
  end

  task automatic set_req(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
    i_ImmSrc = src; i_opcode = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2;
    i_funct3 = f3; i_funct7 = f7; i_immediate = imm; i_valid = 1'b1;
  endtask

  // Holds the request until accepted; returns 1 time unit after the accepting edge
  task automatic issue(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    int w = 0;
    set_req(src, op, rd, rs1, rs2, f3, f7, imm);
    while (!o_ready && w < 50) begin
      @(posedge i_clk); #1; w++;
    end
    if (!o_ready) check("ready_timeout", 32'(o_ready), 32'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic issue_ok(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] word);
    exp_q.push_back(word);
    issue(src, op, rd, rs1, rs2, f3, f7, imm);
  endtask

  task automatic issue_bad(input string tag, input logic [2:0] src, input logic [6:0] op,
                           input logic [31:0] imm);
    issue(src, op, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, imm);
    check({tag, "_err_pulse"}, 32'(o_err), 32'd1);
    exp_err++;
    @(posedge i_clk); #1;
    check({tag, "_err_clear"}, 32'(o_err), 32'd0);
    check({tag, "_err_count"}, 32'(o_err_count), 32'(exp_err));
    check({tag, "_no_write"}, 32'(o_valid), 32'd0);
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge i_clk); #1; w++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] addi_word(input int n);
    return {12'(n), 5'd0, 3'd0, 5'(n + 1), 7'h13};
  endfunction

  initial begin
    int n;
    int acc;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_err", 32'(o_err), 32'd0);
    check("rst_err_count", 32'(o_err_count), 32'd0);
    check("rst_o_instruction", o_instruction, 32'd0);
    i_rst = 1'b0;
    #1;
    check("rst_o_ready", 32'(o_ready), 32'd1);

    // add x1,x2,x3: latency and stability under backpressure
    issue(IMM_R, OP_R, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    check("r_in_stage", 32'(o_valid), 32'd0);
    @(posedge i_clk); #1;
    check("r_valid", 32'(o_valid), 32'd1);
    check("r_word", o_instruction, 32'h003100B3);
    @(posedge i_clk); #1;
    check("r_word_held", o_instruction, 32'h003100B3);
    exp_q.push_back(32'h003100B3);
    i_ready = 1'b1;
    drain();

    // Legal encodings, streamed back to back
    issue_ok(IMM_I, OP_I,   5'd5,  5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00293);
    issue_ok(IMM_S, OP_S,   5'd0,  5'd1, 5'd2, 3'd2, 7'd0, 32'd8,        32'h0020A423);
    issue_ok(IMM_J, OP_JAL, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h001000EF);
    issue_ok(IMM_B, OP_B,   5'd0,  5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE208EE3);
    issue_ok(IMM_U, OP_LUI, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h12345537);
    issue_ok(IMM_I, OP_I,   5'd0,  5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000013);
    issue_ok(IMM_J, OP_JAL, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0, 32'd1048574,  32'h7FFFF06F);
    drain();

    // Illegal requests: dropped with an error pulse
    issue_bad("i_2048",   IMM_I, OP_I,   32'd2048);
    issue_bad("b_odd",    IMM_B, OP_B,   32'd5);
    issue_bad("b_4096",   IMM_B, OP_B,   32'd4096);
    issue_bad("j_max1",   IMM_J, OP_JAL, 32'd1048576);
    issue_bad("u_low",    IMM_U, OP_LUI, 32'h12345001);
    issue_bad("s_m2049",  IMM_S, OP_S,   32'hFFFFF7FF);
    issue_bad("src6",     3'd6,  OP_I,   32'd0);

    // Backpressure: only DEPTH requests fit
    i_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_ready && n < 6) begin
        set_req(IMM_I, OP_I, 5'(n + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(n));
        exp_q.push_back(addi_word(n));
        @(posedge i_clk); #1; n++;
      end else begin
        i_valid = 1'b0;
        @(posedge i_clk); #1;
      end
    end
    i_valid = 1'b0;
    check("bp_accepted", 32'(n), 32'd4);
    check("bp_ready_low", 32'(o_ready), 32'd0);
    check("bp_valid", 32'(o_valid), 32'd1);

    // Full FIFO, then continuous push/pop
    i_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      if (o_ready) begin
        set_req(IMM_I, OP_I, 5'(20 + c + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(20 + c));
        exp_q.push_back(addi_word(20 + c));
        @(posedge i_clk); #1; acc++;
      end else begin
        i_valid = 1'b0;
        @(posedge i_clk); #1;
      end
    end
    i_valid = 1'b0;
    check("stream_accepts", 32'(acc), 32'd11);
    drain();
    check("bp_ready_back", 32'(o_ready), 32'd1);

    // Reset with buffered words and a nonzero error count
    i_ready = 1'b0;
    issue_bad("pre_rst", 3'd7, OP_I, 32'd0);
    for (int k = 0; k < 3; k++)
      issue_ok(IMM_I, OP_I, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), addi_word(k));
    repeat (2) @(posedge i_clk);
    #1;
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    i_rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_err_count", 32'(o_err_count), 32'd0);
    check("mid_rst_ready", 32'(o_ready), 32'd1);
    exp_q.delete();
    exp_err = 0;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    issue_ok(IMM_R, OP_R, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 32'h003100B3);
    drain();
    check("post_rst_err_count", 32'(o_err_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
